// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and limits for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic {IDLE, RD_WAIT} arb_state_t;
    typedef enum logic {CORE = 1'b0, HOST = 1'b1} arb_side_t;
    localparam int MAX_RD_LAT = 4;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin select; on a tie the side that did not win last time wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_side_t  last_i,
    output arb_side_t  side_o,
    output logic       valid_o
);
    assign valid_o = |req_i;
    assign side_o  = (req_i == 2'b11) ? ((last_i == CORE) ? HOST : CORE)
                                      : (req_i[1] ? HOST : CORE);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between core and host, one grant per cycle.
// Optional DMEM_ARB_STATS_EN adds stats_clr and a saturating core wait-cycle counter c_wait_cnt.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   c_wait_cnt
`endif
);
    localparam int LW = $clog2(MAX_RD_LAT);
    arb_state_t state_q, state_d;
    arb_side_t rr_last_q, rr_last_d, owner_q, owner_d, side;
    logic [LW-1:0] lat_q, lat_d;
    logic c_rv_q, c_rv_d, h_rv_q, h_rv_d, pick_v, gnt, is_h, x_we;
    logic [DW-1:0] c_rd_q, c_rd_d, h_rd_q, h_rd_d;
    rr_pick2 u_pick (
        .req_i  ({h_req, c_req}),
        .last_i (rr_last_q),
        .side_o (side),
        .valid_o(pick_v)
    );
    // Gating with reset keeps every output low while reset is held, even with live requests.
    assign gnt       = pick_v & reset & (state_q == IDLE);
    assign is_h      = side == HOST;
    assign x_we      = is_h ? h_we : c_we;
    assign c_gnt     = gnt & ~is_h;
    assign h_gnt     = gnt & is_h;
    assign mem_en    = gnt;
    assign mem_we    = gnt & x_we;
    assign mem_addr  = gnt ? (is_h ? h_addr : c_addr) : '0;
    assign mem_wdata = gnt ? (is_h ? h_wdata : c_wdata) : '0;
    assign stall     = reset & ((c_req & ~c_gnt) | (state_q == RD_WAIT && owner_q == CORE));
    assign c_rvalid  = c_rv_q;
    assign h_rvalid  = h_rv_q;
    assign c_rdata   = c_rd_q;
    assign h_rdata   = h_rd_q;
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        c_rv_d    = 1'b0;
        h_rv_d    = 1'b0;
        c_rd_d    = c_rd_q;
        h_rd_d    = h_rd_q;
        if (state_q == IDLE) begin
            if (gnt) begin
                rr_last_d = side;
                if (!x_we) begin
                    owner_d = side;
                    lat_d   = LW'(RD_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
        end else if (lat_q != '0) begin
            lat_d = lat_q - LW'(1);
        end else begin
            state_d = IDLE;
            if (owner_q == HOST) begin
                h_rv_d = 1'b1;
                h_rd_d = mem_rdata;
            end else begin
                c_rv_d = 1'b1;
                c_rd_d = mem_rdata;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= HOST;
            owner_q   <= CORE;
            lat_q     <= '0;
            c_rv_q    <= 1'b0;
            h_rv_q    <= 1'b0;
            c_rd_q    <= '0;
            h_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            lat_q     <= lat_d;
            c_rv_q    <= c_rv_d;
            h_rv_q    <= h_rv_d;
            c_rd_q    <= c_rd_d;
            h_rd_q    <= h_rd_d;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] wait_q, wait_d;
    assign wait_d     = stats_clr ? 16'h0 : ((c_req & ~c_gnt & ~&wait_q) ? wait_q + 16'd1 : wait_q);
    assign c_wait_cnt = wait_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_q <= 16'h0;
        else wait_q <= wait_d;
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, latency/reset corner sequences and a randomized model check.
module tb_dmem_arbiter;
    typedef struct packed {
        logic       c_gnt, h_gnt, c_rvalid, h_rvalid, stall, mem_en, mem_we;
        logic [7:0] c_rdata, h_rdata, mem_addr, mem_wdata;
    } outs_t;
    typedef struct packed {
        logic       cr, cw;
        logic [7:0] ca, cd;
        logic       hr, hw;
        logic [7:0] ha, hd;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0;
    logic c_req = 0, c_we = 0, h_req = 0, h_we = 0;
    logic [7:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
`ifdef DMEM_ARB_STATS_EN
    logic stats_clr = 1'b0;
    logic [15:0] wcnt1, wcnt3;
`endif
    logic c_gnt1, c_rvalid1, h_gnt1, h_rvalid1, stall1, mem_en1, mem_we1;
    logic [7:0] c_rdata1, h_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic c_gnt3, c_rvalid3, h_gnt3, h_rvalid3, stall3, mem_en3, mem_we3;
    logic [7:0] c_rdata3, h_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    outs_t o1, o3;
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] p1;
    logic [7:0] p3 [3];
    int nchk = 0, npass = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt1), .h_rvalid(h_rvalid1), .h_rdata(h_rdata1),
        .stall(stall1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
`ifdef DMEM_ARB_STATS_EN
        , .stats_clr(stats_clr), .c_wait_cnt(wcnt1)
`endif
    );

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt3), .h_rvalid(h_rvalid3), .h_rdata(h_rdata3),
        .stall(stall3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
`ifdef DMEM_ARB_STATS_EN
        , .stats_clr(stats_clr), .c_wait_cnt(wcnt3)
`endif
    );

    assign o1 = {c_gnt1, h_gnt1, c_rvalid1, h_rvalid1, stall1, mem_en1, mem_we1,
                 c_rdata1, h_rdata1, mem_addr1, mem_wdata1};
    assign o3 = {c_gnt3, h_gnt3, c_rvalid3, h_rvalid3, stall3, mem_en3, mem_we3,
                 c_rdata3, h_rdata3, mem_addr3, mem_wdata3};

    // Memory models: read data appears 1 (dut1) or 3 (dut3) cycles after the read cycle.
    always @(posedge clk) begin
        if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
        if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
        p1    <= mem_addr1;
        p3[0] <= mem_addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata1 = mem1[p1];
    assign mem_rdata3 = mem3[p3[2]];

    function automatic outs_t eo(input logic cg, hg, cv, hv, st, me, mw,
                                 input logic [7:0] crd, hrd, ma, md);
        return {cg, hg, cv, hv, st, me, mw, crd, hrd, ma, md};
    endfunction

    function automatic vec_t vi(input logic cr, cw, input logic [7:0] ca, cd,
                                input logic hr, hw, input logic [7:0] ha, hd, input outs_t e);
        return {cr, cw, ca, cd, hr, hw, ha, hd, e};
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", n, got, exp);
    endtask

    task automatic drv(input logic cr, cw, input logic [7:0] ca, cd,
                       input logic hr, hw, input logic [7:0] ha, hd);
        @(posedge clk);
        #1;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        c_req = 0; h_req = 0; c_we = 0; h_we = 0;
        c_addr = 0; h_addr = 0; c_wdata = 0; h_wdata = 0;
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(negedge clk);
        chk("reset_dut1", o1, '0);
        chk("reset_dut3", o3, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t tab[15];
    outs_t e;
    logic [7:0] rmem [256];
    logic [7:0] ecd, ehd, rd, a, d;
    logic lh, rs, armed, g, gs, we, pcg, phg;
    int wl;
    logic [15:0] wc;

    initial begin
        tab[0]  = vi(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, eo(1,0,0,0,0,1,1,8'h00,8'h00,8'h10,8'hA5));
        tab[1]  = vi(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, eo(1,0,0,0,0,1,0,8'h00,8'h00,8'h10,8'h00));
        tab[2]  = vi(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, eo(0,0,0,0,1,0,0,8'h00,8'h00,8'h00,8'h00));
        tab[3]  = vi(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, eo(0,0,1,0,0,0,0,8'hA5,8'h00,8'h00,8'h00));
        tab[4]  = vi(0,0,8'h00,8'h00, 1,1,8'h11,8'h3C, eo(0,1,0,0,0,1,1,8'hA5,8'h00,8'h11,8'h3C));
        tab[5]  = vi(1,0,8'h10,8'h00, 1,0,8'h11,8'h00, eo(1,0,0,0,0,1,0,8'hA5,8'h00,8'h10,8'h00));
        tab[6]  = vi(1,0,8'h10,8'h00, 1,0,8'h11,8'h00, eo(0,0,0,0,1,0,0,8'hA5,8'h00,8'h00,8'h00));
        tab[7]  = vi(1,0,8'h10,8'h00, 1,0,8'h11,8'h00, eo(0,1,1,0,1,1,0,8'hA5,8'h00,8'h11,8'h00));
        tab[8]  = vi(1,0,8'h10,8'h00, 1,0,8'h11,8'h00, eo(0,0,0,0,1,0,0,8'hA5,8'h00,8'h00,8'h00));
        tab[9]  = vi(1,0,8'h10,8'h00, 1,0,8'h11,8'h00, eo(1,0,0,1,0,1,0,8'hA5,8'h3C,8'h10,8'h00));
        tab[10] = vi(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, eo(0,0,0,0,1,0,0,8'hA5,8'h3C,8'h00,8'h00));
        tab[11] = vi(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, eo(0,0,1,0,0,0,0,8'hA5,8'h3C,8'h00,8'h00));
        tab[12] = vi(1,1,8'h12,8'h11, 1,1,8'h13,8'h22, eo(0,1,0,0,1,1,1,8'hA5,8'h3C,8'h13,8'h22));
        tab[13] = vi(1,1,8'h12,8'h11, 0,0,8'h00,8'h00, eo(1,0,0,0,0,1,1,8'hA5,8'h3C,8'h12,8'h11));
        tab[14] = vi(1,1,8'h14,8'h99, 0,0,8'h00,8'h00, eo(1,0,0,0,0,1,1,8'hA5,8'h3C,8'h14,8'h99));

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drv(tab[i].cr, tab[i].cw, tab[i].ca, tab[i].cd, tab[i].hr, tab[i].hw, tab[i].ha, tab[i].hd);
            chk($sformatf("row%0d", i), o1, tab[i].exp);
        end

        // RD_LAT=3: host read answered 4 cycles after its grant; core waits with stall high.
        do_reset();
        drv(0,0,0,0, 1,1,8'h20,8'h5C);
        chk("lat3_hwrite", o3, eo(0,1,0,0,0,1,1,8'h00,8'h00,8'h20,8'h5C));
        drv(0,0,0,0, 1,0,8'h20,8'h00);
        chk("lat3_hgnt", o3, eo(0,1,0,0,0,1,0,8'h00,8'h00,8'h20,8'h00));
        for (int i = 1; i <= 3; i++) begin
            drv(1,0,8'h20,8'h00, 0,0,0,0);
            chk($sformatf("lat3_wait%0d", i), o3, eo(0,0,0,0,1,0,0,8'h00,8'h00,8'h00,8'h00));
        end
        drv(1,0,8'h20,8'h00, 0,0,0,0);
        chk("lat3_hrvalid", o3, eo(1,0,0,1,0,1,0,8'h00,8'h5C,8'h20,8'h00));
        for (int i = 1; i <= 3; i++) begin
            drv(0,0,0,0, 0,0,0,0);
            chk($sformatf("lat3_cwait%0d", i), o3, eo(0,0,0,0,1,0,0,8'h00,8'h5C,8'h00,8'h00));
`ifdef DMEM_ARB_STATS_EN
            if (i == 1) begin
                chk("wait_cnt3", 64'(wcnt3), 64'd3);
                stats_clr = 1'b1;
            end else if (i == 2) begin
                chk("wait_clr3", 64'(wcnt3), 64'd0);
                stats_clr = 1'b0;
            end
`endif
        end
        drv(0,0,0,0, 0,0,0,0);
        chk("lat3_crvalid", o3, eo(0,0,1,0,0,0,0,8'h5C,8'h5C,8'h00,8'h00));

        // Reset one cycle after a core read grant discards the read.
        do_reset();
        drv(1,0,8'h10,8'h00, 0,0,0,0);
        chk("rst_gnt", o1, eo(1,0,0,0,0,1,0,8'h00,8'h00,8'h10,8'h00));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid", o1, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        c_req = 1'b0;
        @(negedge clk);
        chk("rst_release", o1, '0);
        for (int i = 0; i < 3; i++) begin
            drv(0,0,0,0, 0,0,0,0);
            chk($sformatf("rst_norv%0d", i), o1, '0);
        end
        drv(1,0,8'h10,8'h00, 0,0,0,0);
        chk("rst_regnt", o1, eo(1,0,0,0,0,1,0,8'h00,8'h00,8'h10,8'h00));
        drv(0,0,0,0, 0,0,0,0);
        chk("rst_stall", o1, eo(0,0,0,0,1,0,0,8'h00,8'h00,8'h00,8'h00));
        drv(0,0,0,0, 0,0,0,0);
        chk("rst_rvalid", o1, eo(0,0,1,0,0,0,0,8'hA5,8'h00,8'h00,8'h00));

        // Random traffic vs model: a read blocks the memory for RD_LAT cycles, answers one cycle later.
        do_reset();
        wl = 0; armed = 0; lh = 1; rs = 0; rd = 0; ecd = 0; ehd = 0; wc = 0; pcg = 0; phg = 0;
        for (int i = 0; i < 416; i++) begin
            @(posedge clk);
            #1;
            if (i < 16) begin
                c_req = 0; h_req = 1; h_we = 1; h_addr = 8'(i); h_wdata = 8'($urandom);
            end else begin
                if (c_req && !pcg) begin
                    if ($urandom_range(0, 7) == 0) c_req = 0;
                end else begin
                    c_req = 1'($urandom_range(0, 1)); c_we = 1'($urandom_range(0, 1));
                    c_addr = 8'($urandom_range(0, 15)); c_wdata = 8'($urandom);
                end
                if (h_req && !phg) begin
                    if ($urandom_range(0, 7) == 0) h_req = 0;
                end else begin
                    h_req = 1'($urandom_range(0, 1)); h_we = 1'($urandom_range(0, 1));
                    h_addr = 8'($urandom_range(0, 15)); h_wdata = 8'($urandom);
                end
            end
            @(negedge clk);
            e = '0;
            if (armed && wl == 0) begin
                armed = 0;
                if (rs) begin e.h_rvalid = 1; ehd = rd; end
                else begin e.c_rvalid = 1; ecd = rd; end
            end
            e.c_rdata = ecd;
            e.h_rdata = ehd;
            g = (wl == 0) && (c_req || h_req);
            gs = (c_req && h_req) ? !lh : h_req;
            we = 0; a = 0; d = 0;
            if (g) begin
                we = gs ? h_we : c_we;
                a = gs ? h_addr : c_addr;
                d = gs ? h_wdata : c_wdata;
                e.c_gnt = !gs; e.h_gnt = gs;
                e.mem_en = 1; e.mem_we = we; e.mem_addr = a; e.mem_wdata = d;
                lh = gs;
            end
            e.stall = (c_req && !e.c_gnt) || (wl > 0 && !rs);
            chk($sformatf("rand%0d", i), o1, e);
            if (c_req && !e.c_gnt && wc != 16'hFFFF) wc++;
            if (wl > 0) wl--;
            if (g) begin
                if (we) rmem[a] = d;
                else begin wl = 1; armed = 1; rs = gs; rd = rmem[a]; end
            end
            pcg = e.c_gnt;
            phg = e.h_gnt;
        end
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        chk("wait_cnt1", 64'(wcnt1), 64'(wc));
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
